// File: rtl/rf_multimode.sv
`default_nettype none
// ============================================================================
// Module   : rf_multimode
// Brief    : Parametrised general-purpose register file. Two combinational
//            read ports with same-cycle write bypass, one monitor port that
//            shows committed array content at wr_addr, full / low-half /
//            high-half write modes and a per-register busy scoreboard.
// Config   : define RF_ZERO_REG_EN to hardwire register 0 to zero
//            (writes discarded, no bypass, never busy).
// Revision : 1.0 - initial release
// ============================================================================
module rf_multimode #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_mode,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DATA_W-1:0] mon_data,
  output logic              wr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int HALF  = DATA_W / 2;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_LO   = 2'b01;
  localparam logic [1:0] MODE_HI   = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Architectural state
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_err_q;
  logic              wr_err_d;

  // Write-side decode
  logic              wr_illegal;
  logic              wr_commit;
  logic              rsv_take;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;

  // Qualify write and reserve; register 0 swallows both when hardwired.
  always_comb begin
    wr_illegal = wr_en && (wr_mode == MODE_ILL);
    wr_commit  = wr_en && (wr_mode != MODE_ILL) &&
                 !(ZERO_REG && (wr_addr == '0));
    rsv_take   = rsv_en && !(ZERO_REG && (rsv_addr == '0));
  end

  // Merge incoming data with the current register content by write mode.
  always_comb begin
    wr_old = mem_q[wr_addr];
    case (wr_mode)
      MODE_FULL: wr_merged = wr_data;
      MODE_LO:   wr_merged = {wr_old[DATA_W-1:HALF], wr_data[HALF-1:0]};
      MODE_HI:   wr_merged = {wr_data[DATA_W-1:HALF], wr_old[HALF-1:0]};
      default:   wr_merged = wr_data;
    endcase
  end

  // Next-state for array, scoreboard and error flag; reserve is applied
  // last so it wins over a same-cycle writeback clear.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    busy_d   = busy_q;
    wr_err_d = wr_illegal;
    if (wr_commit) begin
      mem_d[wr_addr]  = wr_merged;
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_take) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Read port 1: bypass the merged write value, and hide busy when this
  // cycle's writeback satisfies the operand without a new reservation.
  always_comb begin
    if (wr_commit && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_merged;
    end else begin
      rd_data1 = mem_q[rd_addr1];
    end
    rd_busy1 = busy_q[rd_addr1] &&
               !(wr_commit && (wr_addr == rd_addr1) &&
                 !(rsv_take && (rsv_addr == rd_addr1)));
  end

  // Read port 2: identical behaviour to port 1.
  always_comb begin
    if (wr_commit && (wr_addr == rd_addr2)) begin
      rd_data2 = wr_merged;
    end else begin
      rd_data2 = mem_q[rd_addr2];
    end
    rd_busy2 = busy_q[rd_addr2] &&
               !(wr_commit && (wr_addr == rd_addr2) &&
                 !(rsv_take && (rsv_addr == rd_addr2)));
  end

  // Monitor port shows committed content only, never the bypass path.
  always_comb begin
    mon_data = mem_q[wr_addr];
    wr_err   = wr_err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_multimode
// Brief    : Scoreboard bench for rf_multimode. The driver computes expected
//            port values from a register-array model and queues them; a
//            monitor pops and compares on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_multimode;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          rd_busy1;
  logic          rd_busy2;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [1:0]    wr_mode = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [DW-1:0] mon_data;
  logic          wr_err;

  rf_multimode #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .rd_busy1 (rd_busy1),
    .rd_busy2 (rd_busy2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_mode  (wr_mode),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .mon_data (mon_data),
    .wr_err   (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] mon;
    logic          b1;
    logic          b2;
    logic          err;
    int            id;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            step = 0;

  // Reference model: plain register array, busy flags, last-cycle error.
  logic [DW-1:0] m_mem [N];
  bit            m_busy[N];
  bit            m_err;

  task automatic check(input string name, input int id,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step=%0d got=%h want=%h", name, id, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_write(input logic [DW-1:0] old,
                                                input logic [DW-1:0] data,
                                                input logic [1:0]    mode);
    logic [DW-1:0] lo_mask;
    logic [DW-1:0] hi_mask;
    lo_mask = {DW{1'b1}} >> (DW / 2);
    hi_mask = ~lo_mask;
    case (mode)
      2'd1:    return (old & hi_mask) | (data & lo_mask);
      2'd2:    return (data & hi_mask) | (old & lo_mask);
      default: return data;
    endcase
  endfunction

  // One clock cycle of stimulus; called at posedge+1. With rst_pulse the
  // reset is held low from now until after the falling-edge sample and
  // write/reserve are withdrawn before the next rising edge.
  task automatic cyc(input bit we, input logic [1:0] mode, input int wa,
                     input logic [DW-1:0] wd, input bit re, input int ra,
                     input int a1, input int a2, input bit rst_pulse);
    exp_t          e;
    bit            valid;
    bit            rsv;
    bit            illegal;
    logic [DW-1:0] mv;
    wr_en    = we;
    wr_mode  = mode;
    wr_addr  = wa[AW-1:0];
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra[AW-1:0];
    rd_addr1 = a1[AW-1:0];
    rd_addr2 = a2[AW-1:0];
    if (rst_pulse) begin
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
    end
    valid   = we && (mode != 2'b11) && !(ZR && wa == 0);
    rsv     = re && !(ZR && ra == 0);
    illegal = we && (mode == 2'b11);
    mv      = model_write(m_mem[wa], wd, mode);
    e.d1    = (valid && wa == a1) ? mv : m_mem[a1];
    e.d2    = (valid && wa == a2) ? mv : m_mem[a2];
    e.b1    = m_busy[a1] && !(valid && wa == a1 && !(rsv && ra == a1));
    e.b2    = m_busy[a2] && !(valid && wa == a2 && !(rsv && ra == a2));
    e.mon   = m_mem[wa];
    e.err   = m_err;
    e.id    = step;
    sb_q.push_back(e);
    if (rst_pulse) begin
      #6;
      wr_en   = 1'b0;
      rsv_en  = 1'b0;
      reset   = 1'b1;
      valid   = 1'b0;
      rsv     = 1'b0;
      illegal = 1'b0;
    end
    @(posedge clk);
    if (valid) begin
      m_mem[wa]  = mv;
      m_busy[wa] = 1'b0;
    end
    if (rsv) m_busy[ra] = 1'b1;
    m_err = illegal;
    #1;
    step++;
  endtask

  task automatic idle(input int a1, input int a2, input int wa);
    cyc(1'b0, 2'd0, wa, '0, 1'b0, 0, a1, a2, 1'b0);
  endtask

  // Monitor: every falling edge the DUT presents its combinational view.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rd_data1", e.id, rd_data1, e.d1);
        check("rd_data2", e.id, rd_data2, e.d2);
        check("rd_busy1", e.id, {{(DW-1){1'b0}}, rd_busy1}, {{(DW-1){1'b0}}, e.b1});
        check("rd_busy2", e.id, {{(DW-1){1'b0}}, rd_busy2}, {{(DW-1){1'b0}}, e.b2});
        check("mon_data", e.id, mon_data, e.mon);
        check("wr_err",   e.id, {{(DW-1){1'b0}}, wr_err}, {{(DW-1){1'b0}}, e.err});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int wa;
    int ra;
    int a1;
    int a2;
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cyc(1'b0, 2'd0, 0, '0, 1'b0, 0, 0, 0, 1'b1);

    // Full write with bypass, then from the array
    cyc(1'b1, 2'd0, 1, 32'hFFFF_FFFF, 1'b0, 0, 1, 1, 1'b0);
    idle(1, 1, 1);

    // Half writes to r9
    cyc(1'b1, 2'd0, 9, 32'h0, 1'b0, 0, 9, 9, 1'b0);
    cyc(1'b1, 2'd2, 9, 32'hAAAA_AAAA, 1'b0, 0, 9, 9, 1'b0);
    cyc(1'b1, 2'd1, 9, 32'h5555_5555, 1'b0, 0, 9, 9, 1'b0);
    idle(9, 9, 9);

    // Scoreboard on r3
    cyc(1'b0, 2'd0, 0, '0, 1'b1, 3, 3, 3, 1'b0);
    idle(3, 3, 3);
    cyc(1'b1, 2'd0, 3, 32'h1111_1111, 1'b0, 0, 3, 3, 1'b0);
    idle(3, 3, 3);
    cyc(1'b1, 2'd0, 3, 32'h2222_2222, 1'b1, 3, 3, 3, 1'b0);
    idle(3, 3, 3);
    cyc(1'b1, 2'd0, 3, 32'h3333_3333, 1'b1, 3, 3, 3, 1'b0);

    // Illegal mode on a busy r1
    cyc(1'b1, 2'd0, 1, 32'h1234_5678, 1'b1, 1, 1, 1, 1'b0);
    cyc(1'b1, 2'd3, 1, 32'hCAFE_F00D, 1'b0, 0, 1, 1, 1'b0);
    idle(1, 1, 1);
    idle(1, 1, 1);

    // Asynchronous reset while r5 holds data and is busy
    cyc(1'b1, 2'd0, 5, 32'hDEAD_BEEF, 1'b1, 5, 5, 5, 1'b0);
    idle(5, 5, 5);
    cyc(1'b0, 2'd0, 5, '0, 1'b0, 0, 5, 5, 1'b1);
    idle(5, 5, 5);

    // Bypass still visible while in reset; write must not commit
    cyc(1'b1, 2'd0, 2, 32'h0BAD_F00D, 1'b1, 2, 2, 2, 1'b1);
    idle(2, 2, 2);

    // Register 0 write plus reserve
    cyc(1'b1, 2'd0, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 1'b0);
    idle(0, 0, 0);
    cyc(1'b1, 2'd1, 0, 32'h1234_5678, 1'b0, 0, 0, 1, 1'b0);
    idle(0, 0, 0);

    // Randomized traffic over a narrow address range to force collisions
    for (int k = 0; k < 500; k++) begin
      wa = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
      a2 = ($urandom_range(0, 2) == 0) ? ra : $urandom_range(0, 7);
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), wa, $urandom,
          $urandom_range(0, 2) == 0, ra, a1, a2, $urandom_range(0, 79) == 0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", step, sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_multimode.md
# rf_multimode

Parametrised general-purpose register file for the CPU datapath, succeeding the fixed 16×32 RF. It provides two combinational read ports with same-cycle write bypass and one registered-array monitor port. The write port supports full, low-half and high-half writes, generalising the old single high/low select. A per-register busy scoreboard lets the control unit stall on operands whose producer has not yet written back.

## Interface
Parameters:
- DATA_W, 32, register width in bits; must be even (half = DATA_W/2).
- ADDR_W, 4, address width; depth = 2**ADDR_W registers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state while low.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, with bypass.
- rd_data2  out  DATA_W  read port 2 data, with bypass.
- rd_busy1  out  1  register at rd_addr1 is awaiting writeback.
- rd_busy2  out  1  register at rd_addr2 is awaiting writeback.
- wr_en  in  1  write request this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_mode  in  2  write mode: 00 full, 01 low half, 10 high half, 11 illegal.
- wr_data  in  DATA_W  write data. Half modes take the half from the same bit lanes it lands in.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- mon_data  out  DATA_W  committed array content at wr_addr, with no bypass.
- wr_err  out  1  registered flag; high for one cycle after an illegal write.

## Operation
- Storage: array of 2**ADDR_W × DATA_W flops, plus a busy bit per register.
- Valid write: wr_en=1 and wr_mode≠11.
- Merge rules for the written value:
  - Full mode: wr_data.
  - Low-half mode: {old[DATA_W-1:DATA_W/2], wr_data[DATA_W/2-1:0]}.
  - High-half mode: {wr_data[DATA_W-1:DATA_W/2], old[DATA_W/2-1:0]}.
- The merged value is committed on the rising edge.
- Illegal write (wr_en=1, wr_mode=11):
  - The array and busy bits are unchanged.
  - wr_err=1 for the following cycle only.
- Read bypass: if a valid write targets rd_addrN this cycle, rd_dataN returns the merged value; otherwise it returns the array content.
- Both read ports may address the same register, or the write register, simultaneously.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - A valid write clears busy[wr_addr] at the edge.
  - Reserve and valid write to the same address in the same cycle: the reserve wins and busy stays 1 (new producer). The data is still written.
- rd_busyN = busy[rd_addrN] AND NOT (a valid write to rd_addrN this cycle with no same-cycle reserve of that address). This keeps rd_busyN consistent with the bypassed data.
- Reserving an already-busy register leaves it busy. Writing a non-busy register is legal and leaves busy at 0.

## Timing
- Reads, bypass, rd_busy and mon_data are combinational, with zero cycles of latency.
- Array and busy updates: one rising edge after wr_en/rsv_en are sampled.
- wr_err: registered, asserted in the cycle after the illegal request.
- While reset=0:
  - Every register, every busy bit and wr_err are 0.
  - rd_data1, rd_data2 and mon_data read 0, except that rd_dataN still shows a bypassed value if a valid write to rd_addrN is presented.
  - rd_busy1 and rd_busy2 are 0.
  - Writes and reserves are ignored.
- Reset asserted mid-operation: state clears immediately, without waiting for clk. The first edge after reset rises acts normally.

## Configuration
- RF_ZERO_REG_EN defined:
  - Register 0 is hardwired to zero; writes to it are discarded.
  - No bypass applies for address 0; reads of address 0 return 0.
  - busy[0] is never set; rd_busy for address 0 is always 0.
  - An illegal-mode write to address 0 still raises wr_err.
- RF_ZERO_REG_EN undefined: register 0 is an ordinary register.

## Test plan
- Reset, then full write 32'hFFFFFFFF to r1 → rd_data1 (addr 1) shows FFFFFFFF in the same cycle via bypass and after the edge from the array. mon_data is 0 before the edge and FFFFFFFF after.
- r9=0. Write AAAAAAAA in high-half mode, then 55555555 in low-half mode, to r9 → r9 reads AAAA0000, then AAAA5555.
- Reserve r3 → rd_busy2 (addr 3) is 1 from the next cycle. A valid write to r3 drops rd_busy2 in the write cycle itself and it stays 0 afterwards. Reserve and write r3 in the same cycle → busy stays 1 and the data updates.
- wr_en with wr_mode=11 to r1 holding 12345678 → r1 is unchanged, wr_err=1 for exactly one cycle, and any busy bit on r1 is unchanged.
- Reset pulsed low between clock edges while r5=DEADBEEF and r5 is busy → rd_data and mon_data read 0 and rd_busy reads 0 immediately, before the next edge.
- With RF_ZERO_REG_EN: write FFFFFFFF to r0 and reserve r0 → rd_data1 (addr 0) stays 0 in the write cycle and after, and rd_busy1 stays 0.
